// File: rtl/ram_banked_pkg.sv
// rtl/ram_banked_pkg.sv - shared state type and address-to-bank helpers for the banked RAM controller
package ram_banked_pkg;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Bank index for a flat word address; callers truncate to their index width.
    function automatic logic [31:0] bank_sel(input logic [31:0] addr, input int unsigned aw,
                                             input int unsigned bw, input bit interleave);
        logic [31:0] mask;
        mask = (32'd1 << bw) - 32'd1;
        if (bw == 0) begin
            return '0;
        end
        if (interleave) begin
            return addr & mask;
        end
        return (addr >> (aw - bw)) & mask;
    endfunction

    function automatic logic [31:0] bank_word(input logic [31:0] addr, input int unsigned aw,
                                              input int unsigned bw, input bit interleave);
        if (interleave) begin
            return addr >> bw;
        end
        return addr & ((32'd1 << (aw - bw)) - 32'd1);
    endfunction

endpackage

// File: rtl/ram_banked_scrub.sv
// rtl/ram_banked_scrub.sv - zero-scrub sequencer: walks every bank word once, then hands over to normal service
module ram_banked_scrub
    import ram_banked_pkg::*;
#(
    parameter int unsigned BankDepth    = 512,
    parameter int unsigned AddrW        = 9,
    parameter int unsigned ScrubOnReset = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_req_i,
    output logic             active_o,
    output logic [AddrW-1:0] addr_o,
    output logic             done_o
);

    localparam state_e ResetState = (ScrubOnReset != 0) ? ST_SCRUB : ST_RUN;

    state_e           state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        unique case (state_q)
            ST_SCRUB: begin
                // init_req_i is deliberately not looked at here: a running scrub never restarts.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AddrW'(BankDepth - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (init_req_i) begin
                    state_d = ST_SCRUB;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ResetState;
            cnt_q   <= '0;
            done_q  <= (ScrubOnReset == 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign active_o = (state_q == ST_SCRUB);
    assign addr_o   = cnt_q;
    assign done_o   = done_q;

endmodule

// File: rtl/ram_banked_ctrl.sv
// rtl/ram_banked_ctrl.sv - SRAM-port to NumBanks single-port bank controller with scrub and read-return pipeline
module ram_banked_ctrl
    import ram_banked_pkg::*;
#(
    parameter int unsigned Width        = 32,
    parameter int unsigned Depth        = 2048,
    parameter int unsigned NumBanks     = 4,
    parameter int unsigned Interleave   = 1,
    parameter int unsigned OutputReg    = 0,
    parameter int unsigned ScrubOnReset = 1,
    localparam int unsigned Aw          = $clog2(Depth),
    localparam int unsigned Bw          = $clog2(NumBanks),
    localparam int unsigned BankDepth   = Depth / NumBanks,
    localparam int unsigned BankAw      = Aw - Bw
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic                      we_i,
    input  logic [Aw-1:0]             addr_i,
    input  logic [Width-1:0]          wdata_i,
    input  logic [Width-1:0]          wmask_i,
    output logic [Width-1:0]          rdata_o,
    output logic                      rvalid_o,
    input  logic                      init_req_i,
    output logic                      init_done_o,
    output logic [NumBanks-1:0]       bank_req_o,
    output logic                      bank_we_o,
    output logic [BankAw-1:0]         bank_addr_o,
    output logic [Width-1:0]          bank_wdata_o,
    output logic [Width-1:0]          bank_wmask_o,
    input  logic [NumBanks*Width-1:0] bank_rdata_i
);

    localparam int unsigned BwS = (Bw > 0) ? Bw : 1;

    logic              scrub_active;
    logic              scrub_done;
    logic [BankAw-1:0] scrub_addr;
    logic [BwS-1:0]    bank_idx;
    logic [BankAw-1:0] word_addr;
    logic              accept;

    ram_banked_scrub #(
        .BankDepth   (BankDepth),
        .AddrW       (BankAw),
        .ScrubOnReset(ScrubOnReset)
    ) u_scrub (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .init_req_i(init_req_i),
        .active_o  (scrub_active),
        .addr_o    (scrub_addr),
        .done_o    (scrub_done)
    );

    always_comb begin
        bank_idx  = BwS'(bank_sel(32'(addr_i), Aw, Bw, Interleave != 0));
        word_addr = BankAw'(bank_word(32'(addr_i), Aw, Bw, Interleave != 0));
    end

    assign gnt_o       = !scrub_active && !init_req_i;
    assign accept      = req_i && gnt_o;
    assign init_done_o = scrub_done;

    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = we_i;
        bank_addr_o  = word_addr;
        bank_wdata_o = wdata_i;
        bank_wmask_o = wmask_i;
        // Banks are left untouched while reset is held, even though the scrub state is already loaded.
        if (!rst_ni) begin
            bank_req_o = '0;
        end else if (scrub_active) begin
            bank_req_o   = '1;
            bank_we_o    = 1'b1;
            bank_addr_o  = scrub_addr;
            bank_wdata_o = '0;
            bank_wmask_o = '1;
        end else if (accept) begin
            bank_req_o[bank_idx] = 1'b1;
        end
    end

    logic           rd_pend_q, rd_pend_d;
    logic [BwS-1:0] rd_bank_q, rd_bank_d;
    logic [Width-1:0] rd_mux;

    always_comb begin
        rd_pend_d = accept && !we_i;
        rd_bank_d = accept ? bank_idx : rd_bank_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_q <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NumBanks; k++) begin
            if (rd_bank_q == BwS'(k)) begin
                rd_mux = bank_rdata_i[k*Width +: Width];
            end
        end
    end

    if (OutputReg != 0) begin : g_oreg
        logic             rvalid_q, rvalid_d;
        logic [Width-1:0] rdata_q, rdata_d;

        always_comb begin
            rvalid_d = rd_pend_q;
            rdata_d  = rd_pend_q ? rd_mux : rdata_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end

        assign rvalid_o = rvalid_q;
        assign rdata_o  = rdata_q;
    end else begin : g_ocomb
        assign rvalid_o = rd_pend_q;
        assign rdata_o  = rd_pend_q ? rd_mux : '0;
    end

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// tb/tb_ram_banked_ctrl.sv - directed bench: three controller variants sharing stimulus, each with its own bank models
module tb_ram_banked_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni, req_i, we_i, init_req_i;
    logic [10:0] addr_i;
    logic [31:0] wdata_i, wmask_i;

    logic        gnt [3];
    logic        rvalid [3];
    logic        init_done [3];
    logic        bank_we [3];
    logic [31:0] rdata [3];
    logic [31:0] bank_wdata [3];
    logic [31:0] bank_wmask [3];
    logic [3:0]  bank_req [3];
    logic [8:0]  bank_addr [3];

    int n_chk  = 0;
    int n_pass = 0;

    // Instance 0: interleaved, combinational output. 1: interleaved, registered output. 2: contiguous.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0]  mem [4][512];
        logic [127:0] brd;

        ram_banked_ctrl #(
            .Width       (32),
            .Depth       (2048),
            .NumBanks    (4),
            .Interleave  ((g == 2) ? 0 : 1),
            .OutputReg   ((g == 1) ? 1 : 0),
            .ScrubOnReset(1)
        ) u_dut (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .req_i       (req_i),
            .gnt_o       (gnt[g]),
            .we_i        (we_i),
            .addr_i      (addr_i),
            .wdata_i     (wdata_i),
            .wmask_i     (wmask_i),
            .rdata_o     (rdata[g]),
            .rvalid_o    (rvalid[g]),
            .init_req_i  (init_req_i),
            .init_done_o (init_done[g]),
            .bank_req_o  (bank_req[g]),
            .bank_we_o   (bank_we[g]),
            .bank_addr_o (bank_addr[g]),
            .bank_wdata_o(bank_wdata[g]),
            .bank_wmask_o(bank_wmask[g]),
            .bank_rdata_i(brd)
        );

        always @(posedge clk_i) begin
            for (int k = 0; k < 4; k++) begin
                if (bank_req[g][k]) begin
                    if (bank_we[g]) begin
                        mem[k][bank_addr[g]] <= (mem[k][bank_addr[g]] & ~bank_wmask[g]) |
                                                (bank_wdata[g] & bank_wmask[g]);
                    end else begin
                        brd[k*32 +: 32] <= mem[k][bank_addr[g]];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [31:0] m);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; wmask_i = m;
        tick();
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [10:0] a, input logic [31:0] exp);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        tick();
        req_i = 1'b0;
        #1;
        check({tag, ".v0"}, 32'(rvalid[0]), 32'd1);
        check({tag, ".d0"}, rdata[0], exp);
        check({tag, ".v2"}, 32'(rvalid[2]), 32'd1);
        check({tag, ".d2"}, rdata[2], exp);
        check({tag, ".v1_early"}, 32'(rvalid[1]), 32'd0);
        tick();
        #1;
        check({tag, ".v1"}, 32'(rvalid[1]), 32'd1);
        check({tag, ".d1"}, rdata[1], exp);
        check({tag, ".v0_once"}, 32'(rvalid[0]), 32'd0);
        tick();
    endtask

    // Checks n scrub cycles: grants blocked, every bank written with zero at the running count.
    task automatic scrub_span(input string tag, input int n, input int pulse_at, input int rv_from);
        int bad_at;
        bad_at = -1;
        for (int i = 0; i < n; i++) begin
            init_req_i = (i == pulse_at);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (gnt[g] !== 1'b0 || init_done[g] !== 1'b0 || bank_req[g] !== 4'hf ||
                    bank_we[g] !== 1'b1 || bank_addr[g] !== 9'(i) || bank_wdata[g] !== 32'd0 ||
                    bank_wmask[g] !== 32'hffff_ffff || (i >= rv_from && rvalid[g] !== 1'b0)) begin
                    if (bad_at < 0) bad_at = i;
                end
            end
            if (i < n - 1) tick();
        end
        init_req_i = 1'b0;
        check({tag, ".first_bad_cycle"}, 32'(bad_at), 32'hffff_ffff);
    endtask

    logic [31:0] vals [4];

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; init_req_i = 1'b0;
        addr_i = '0; wdata_i = '0; wmask_i = '0;
        repeat (3) tick();
        #1;
        check("rst.rvalid0", 32'(rvalid[0]), 32'd0);
        check("rst.rvalid1", 32'(rvalid[1]), 32'd0);
        check("rst.rdata0", rdata[0], 32'd0);
        check("rst.rdata1", rdata[1], 32'd0);
        check("rst.bank_req", 32'(bank_req[0]), 32'd0);
        check("rst.init_done", 32'(init_done[0]), 32'd0);
        check("rst.gnt", 32'(gnt[0]), 32'd0);

        tick();
        rst_ni = 1'b1;
        scrub_span("scrub_por", 512, -1, 0);
        tick();
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("por_done%0d", g), 32'(init_done[g]), 32'd1);
            check($sformatf("por_gnt%0d", g), 32'(gnt[g]), 32'd1);
        end

        // Read of a scrubbed location.
        req_i = 1'b1; we_i = 1'b0; addr_i = 11'h123;
        #1;
        check("rd123.bank_req0", 32'(bank_req[0]), 32'h8);
        check("rd123.bank_addr0", 32'(bank_addr[0]), 32'h48);
        check("rd123.bank_req2", 32'(bank_req[2]), 32'h1);
        check("rd123.bank_addr2", 32'(bank_addr[2]), 32'h123);
        rd("rd123", 11'h123, 32'd0);

        // Full-mask write then read next cycle.
        req_i = 1'b1; we_i = 1'b1; addr_i = 11'd5; wdata_i = 32'hDEAD_BEEF; wmask_i = 32'hffff_ffff;
        #1;
        check("wr5.bank_req", 32'(bank_req[0]), 32'h2);
        check("wr5.bank_addr", 32'(bank_addr[0]), 32'd1);
        check("wr5.bank_we", 32'(bank_we[0]), 32'd1);
        check("wr5.bank_wdata", bank_wdata[0], 32'hDEAD_BEEF);
        tick();
        req_i = 1'b1; we_i = 1'b0;
        #1;
        check("wr5.no_rvalid", 32'(rvalid[0]), 32'd0);
        rd("rd5", 11'd5, 32'hDEAD_BEEF);

        wr(11'd5, 32'h1122_3344, 32'h0000_ffff);
        rd("rd5_mask", 11'd5, 32'hDEAD_3344);

        // Back-to-back reads across all four interleaved banks.
        for (int i = 0; i < 4; i++) begin
            vals[i] = 32'hC0FF_EE00 | 32'(i);
            wr(11'(4 + i), vals[i], 32'hffff_ffff);
        end
        for (int w = 0; w < 6; w++) begin
            if (w < 4) begin
                req_i = 1'b1; we_i = 1'b0; addr_i = 11'(4 + w);
            end else begin
                req_i = 1'b0;
            end
            #1;
            if (w < 4) check($sformatf("b2b.bank_req.w%0d", w), 32'(bank_req[0]), 32'(1 << w));
            check($sformatf("b2b.v0.w%0d", w), 32'(rvalid[0]), 32'(w >= 1 && w <= 4));
            if (w >= 1 && w <= 4) check($sformatf("b2b.d0.w%0d", w), rdata[0], vals[w-1]);
            check($sformatf("b2b.v1.w%0d", w), 32'(rvalid[1]), 32'(w >= 2 && w <= 5));
            if (w >= 2 && w <= 5) check($sformatf("b2b.d1.w%0d", w), rdata[1], vals[w-2]);
            if (w >= 1 && w <= 4) check($sformatf("b2b.d2.w%0d", w), rdata[2], vals[w-1]);
            tick();
        end

        // Contiguous mapping: 0x200 is word 0 of bank 1.
        req_i = 1'b1; we_i = 1'b1; addr_i = 11'h200; wdata_i = 32'hCAFE_F00D; wmask_i = 32'hffff_ffff;
        #1;
        check("wr200.bank_req2", 32'(bank_req[2]), 32'h2);
        check("wr200.bank_addr2", 32'(bank_addr[2]), 32'd0);
        check("wr200.bank_req0", 32'(bank_req[0]), 32'h1);
        tick();
        req_i = 1'b0; we_i = 1'b0;
        rd("rd200", 11'h200, 32'hCAFE_F00D);

        // Read accepted, then scrub requested while it returns; request held through the scrub.
        wr(11'd5, 32'hDEAD_BEEF, 32'hffff_ffff);
        req_i = 1'b1; we_i = 1'b0; addr_i = 11'd5;
        #1;
        check("pre_init.gnt", 32'(gnt[0]), 32'd1);
        tick();
        init_req_i = 1'b1;
        #1;
        check("init.gnt", 32'(gnt[0]), 32'd0);
        check("init.bank_req", 32'(bank_req[0]), 32'd0);
        check("init.v0", 32'(rvalid[0]), 32'd1);
        check("init.d0", rdata[0], 32'hDEAD_BEEF);
        tick();
        init_req_i = 1'b0;
        #1;
        check("init.v1", 32'(rvalid[1]), 32'd1);
        check("init.d1", rdata[1], 32'hDEAD_BEEF);
        scrub_span("scrub_req", 512, 200, 1);
        tick();
        #1;
        check("post_scrub.gnt", 32'(gnt[0]), 32'd1);
        check("post_scrub.init_done", 32'(init_done[0]), 32'd1);
        check("post_scrub.bank_req", 32'(bank_req[0]), 32'h2);
        tick();
        req_i = 1'b0;
        #1;
        check("post_scrub.v0", 32'(rvalid[0]), 32'd1);
        check("post_scrub.d0", rdata[0], 32'd0);
        check("post_scrub.d2", rdata[2], 32'd0);
        tick();
        #1;
        check("post_scrub.v1", 32'(rvalid[1]), 32'd1);
        check("post_scrub.d1", rdata[1], 32'd0);
        tick();

        // Reset while a read is in flight drops its return.
        req_i = 1'b1; we_i = 1'b0; addr_i = 11'd5;
        tick();
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("rst_rd.v0", 32'(rvalid[0]), 32'd0);
        check("rst_rd.v1", 32'(rvalid[1]), 32'd0);
        check("rst_rd.init_done", 32'(init_done[0]), 32'd0);
        tick();
        #1;
        check("rst_rd.v1_late", 32'(rvalid[1]), 32'd0);
        tick();
        rst_ni = 1'b1;

        // Reset again at scrub count 100; the scrub must restart from zero.
        scrub_span("scrub_partial", 101, -1, 0);
        rst_ni = 1'b0;
        #1;
        check("rst_mid.bank_req", 32'(bank_req[0]), 32'd0);
        check("rst_mid.init_done", 32'(init_done[0]), 32'd0);
        check("rst_mid.rvalid", 32'(rvalid[0]), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        scrub_span("scrub_restart", 512, -1, 0);
        tick();
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("restart_done%0d", g), 32'(init_done[g]), 32'd1);
        end
        rd("rd200_final", 11'h200, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
